// File: rtl/dh_exchange_ctrl_pkg.sv
// Shared encodings for the Diffie-Hellman exchange controller and its helpers.
package dh_exchange_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT     = 3'd2,
    CHECK    = 3'd3,
    ENC      = 3'd4,
    ENC_WAIT = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } state_e;

  localparam logic [1:0] JOB_PUB_A = 2'd0;
  localparam logic [1:0] JOB_PUB_B = 2'd1;
  localparam logic [1:0] JOB_KEY_A = 2'd2;
  localparam logic [1:0] JOB_KEY_B = 2'd3;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_TMO      = 3'd1;
  localparam logic [2:0] ERR_MISMATCH = 3'd2;
  localparam logic [2:0] ERR_ENC      = 3'd3;
  localparam logic [2:0] ERR_MOD      = 3'd4;

endpackage

// File: rtl/dh_exchange_ctrl_job_mux.sv
// Operand select for one modexp job: picks base and exponent from the job index.
module dh_job_mux
  import dh_exchange_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   job,
  input  logic [W-1:0] g,
  input  logic [W-1:0] xa,
  input  logic [W-1:0] xb,
  input  logic [W-1:0] pub_a,
  input  logic [W-1:0] pub_b,
  output logic [W-1:0] base_o,
  output logic [W-1:0] exp_o
);

  always_comb begin
    base_o = g;
    exp_o  = xa;
    case (job)
      JOB_PUB_A: begin base_o = g;     exp_o = xa; end
      JOB_PUB_B: begin base_o = g;     exp_o = xb; end
      JOB_KEY_A: begin base_o = pub_b; exp_o = xa; end
      JOB_KEY_B: begin base_o = pub_a; exp_o = xb; end
      default:   begin base_o = g;     exp_o = xa; end
    endcase
  end

endmodule

// File: rtl/dh_exchange_ctrl.sv
// Runs a two-party DH exchange as four jobs on a shared modexp unit, cross-checks
// the two shared keys and then hands off to the encryption stage.
module dh_exchange_ctrl
  import dh_exchange_ctrl_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = 1024,
  parameter int ENC_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] p,
  input  logic [W-1:0] g,
  input  logic [W-1:0] xa,
  input  logic [W-1:0] xb,
  output logic         me_start,
  output logic [W-1:0] me_base,
  output logic [W-1:0] me_exp,
  output logic [W-1:0] me_mod,
  input  logic         me_done,
  input  logic [W-1:0] me_result,
  output logic         enc_go,
  input  logic         enc_true,
  output logic [W-1:0] pub_a,
  output logic [W-1:0] pub_b,
  output logic [W-1:0] key,
  output logic         busy,
  output logic         done,
  output logic [2:0]   err_code
);

  localparam int CNT_MAX = (TIMEOUT > ENC_LAT) ? TIMEOUT : ENC_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ENC_LAST = CW'(ENC_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    job_q, job_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  p_q, p_d, g_q, g_d, xa_q, xa_d, xb_q, xb_d;
  logic [W-1:0]  pub_a_q, pub_a_d, pub_b_q, pub_b_d;
  logic [W-1:0]  key_a_q, key_a_d, key_b_q, key_b_d, key_q, key_d;
  logic [2:0]    err_q, err_d;

  dh_job_mux #(.W(W)) u_job_mux (
    .job    (job_q),
    .g      (g_q),
    .xa     (xa_q),
    .xb     (xb_q),
    .pub_a  (pub_a_q),
    .pub_b  (pub_b_q),
    .base_o (me_base),
    .exp_o  (me_exp)
  );

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    g_d      = g_q;
    xa_d     = xa_q;
    xb_d     = xb_q;
    pub_a_d  = pub_a_q;
    pub_b_d  = pub_b_q;
    key_a_d  = key_a_q;
    key_b_d  = key_b_q;
    key_d    = key_q;
    err_d    = err_q;
    me_start = 1'b0;
    enc_go   = 1'b0;

    case (state_q)
      // DONE and ERR accept a new exchange exactly like IDLE
      IDLE, DONE, ERR: begin
        if (start) begin
          p_d   = p;
          g_d   = g;
          xa_d  = xa;
          xb_d  = xb;
          job_d = JOB_PUB_A;
          err_d = ERR_NONE;
          if (p < W'(2)) begin
            state_d = ERR;
            err_d   = ERR_MOD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        me_start = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A completion arriving on the timeout cycle still counts
        if (me_done) begin
          case (job_q)
            JOB_PUB_A: pub_a_d = me_result;
            JOB_PUB_B: pub_b_d = me_result;
            JOB_KEY_A: key_a_d = me_result;
            default:   key_b_d = me_result;
          endcase
          if (job_q == JOB_KEY_B) begin
            state_d = CHECK;
          end else begin
            job_d   = job_q + 2'd1;
            state_d = ISSUE;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = ERR;
          err_d   = ERR_TMO;
        end
      end
      CHECK: begin
        if (key_a_q != key_b_q) begin
          state_d = ERR;
          err_d   = ERR_MISMATCH;
        end else begin
          key_d   = key_a_q;
          state_d = ENC;
        end
      end
      ENC: begin
        enc_go  = 1'b1;
        cnt_d   = '0;
        state_d = ENC_WAIT;
      end
      ENC_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == ENC_LAST) begin
          if (enc_true) begin
            state_d = DONE;
          end else begin
            state_d = ERR;
            err_d   = ERR_ENC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      job_q   <= JOB_PUB_A;
      cnt_q   <= '0;
      p_q     <= '0;
      g_q     <= '0;
      xa_q    <= '0;
      xb_q    <= '0;
      pub_a_q <= '0;
      pub_b_q <= '0;
      key_a_q <= '0;
      key_b_q <= '0;
      key_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      g_q     <= g_d;
      xa_q    <= xa_d;
      xb_q    <= xb_d;
      pub_a_q <= pub_a_d;
      pub_b_q <= pub_b_d;
      key_a_q <= key_a_d;
      key_b_q <= key_b_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  assign me_mod   = p_q;
  assign pub_a    = pub_a_q;
  assign pub_b    = pub_b_q;
  assign key      = key_q;
  assign err_code = err_q;
  assign done     = (state_q == DONE) || (state_q == ERR);
  assign busy     = (state_q != IDLE) && !done;

endmodule

// File: tb/tb_dh_exchange_ctrl.sv
// Directed bench for dh_exchange_ctrl with a behavioural modexp unit and encryption stub.
module tb_dh_exchange_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] p = '0, g = '0, xa = '0, xb = '0;
  logic        me_start, enc_go, busy, done;
  logic [31:0] me_base, me_exp, me_mod, pub_a, pub_b, key;
  logic        me_done = 1'b0;
  logic [31:0] me_result = '0;
  logic        enc_true = 1'b1;
  logic [2:0]  err_code;

  int n_vec = 0;
  int n_mis = 0;

  // modexp model controls and logs
  int          ms_cnt = 0;
  int          eg_cnt = 0;
  int          run_base = 0;
  int          drop_job = -1;
  bit          corrupt = 1'b0;
  int          lat = 0;
  int          jb;
  logic [31:0] res_m = '0;
  logic [31:0] base_log [64];
  logic [31:0] exp_log  [64];

  dh_exchange_ctrl #(.W(32), .TIMEOUT(16), .ENC_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .p(p), .g(g), .xa(xa), .xb(xb),
    .me_start(me_start), .me_base(me_base), .me_exp(me_exp), .me_mod(me_mod),
    .me_done(me_done), .me_result(me_result), .enc_go(enc_go), .enc_true(enc_true),
    .pub_a(pub_a), .pub_b(pub_b), .key(key), .busy(busy), .done(done),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] m);
    logic [63:0] r, x, mm;
    if (m == 32'd0) return 32'd0;
    mm = {32'd0, m};
    r  = 64'd1 % mm;
    x  = {32'd0, b} % mm;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[31:0];
  endfunction

  always @(posedge clk) begin
    me_done <= 1'b0;
    if (lat != 0) begin
      lat = lat - 1;
      if (lat == 0) begin
        me_done   <= 1'b1;
        me_result <= res_m;
      end
    end
    if (me_start) begin
      jb = ms_cnt - run_base;
      if (ms_cnt < 64) begin
        base_log[ms_cnt] = me_base;
        exp_log[ms_cnt]  = me_exp;
      end
      ms_cnt = ms_cnt + 1;
      res_m  = modexp(me_base, me_exp, me_mod);
      if (corrupt && jb == 3) res_m = 32'd7;
      if (jb != drop_job) lat = 3;
    end
    if (enc_go) eg_cnt = eg_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] vp, input logic [31:0] vg,
                          input logic [31:0] vxa, input logic [31:0] vxb);
    @(negedge clk);
    p = vp; g = vg; xa = vxa; xb = vxb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check_val("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic nominal_run(input string pfx);
    int eg0;
    run_base = ms_cnt;
    eg0 = eg_cnt;
    do_start(32'd23, 32'd5, 32'd6, 32'd15);
    check_val({pfx, "_busy"}, busy, 1);
    wait_done(200);
    check_val({pfx, "_pub_a"}, pub_a, 8);
    check_val({pfx, "_pub_b"}, pub_b, 19);
    check_val({pfx, "_key"}, key, 2);
    check_val({pfx, "_err"}, err_code, 0);
    check_val({pfx, "_done"}, done, 1);
    check_val({pfx, "_idle_busy"}, busy, 0);
    check_val({pfx, "_n_me_start"}, ms_cnt - run_base, 4);
    check_val({pfx, "_n_enc_go"}, eg_cnt - eg0, 1);
  endtask

  initial begin
    int ms0, eg0, n;

    // reset state
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err_code, 0);
    check_val("rst_pub_a", pub_a, 0);
    check_val("rst_key", key, 0);
    check_val("rst_me_start", me_start, 0);
    check_val("rst_me_base", me_base, 0);
    check_val("rst_enc_go", enc_go, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // nominal exchange with operand trace
    nominal_run("nom");
    check_val("nom_base0", base_log[run_base + 0], 5);
    check_val("nom_base1", base_log[run_base + 1], 5);
    check_val("nom_base2", base_log[run_base + 2], 19);
    check_val("nom_base3", base_log[run_base + 3], 8);
    check_val("nom_exp0", exp_log[run_base + 0], 6);
    check_val("nom_exp1", exp_log[run_base + 1], 15);
    check_val("nom_exp2", exp_log[run_base + 2], 6);
    check_val("nom_exp3", exp_log[run_base + 3], 15);

    // bad modulus
    ms0 = ms_cnt;
    do_start(32'd1, 32'd5, 32'd6, 32'd15);
    check_val("badmod_done", done, 1);
    check_val("badmod_err", err_code, 4);
    repeat (3) @(negedge clk);
    check_val("badmod_no_me_start", ms_cnt - ms0, 0);

    // timeout on job 1
    drop_job = 1;
    run_base = ms_cnt;
    do_start(32'd23, 32'd5, 32'd6, 32'd15);
    n = 0;
    while (ms_cnt - run_base < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("tmo_second_issue", ms_cnt - run_base, 2);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check_val("tmo_err_early", err_code, 0);
    @(posedge clk);
    @(negedge clk);
    check_val("tmo_err", err_code, 1);
    check_val("tmo_done", done, 1);
    check_val("tmo_pub_a", pub_a, 8);
    drop_job = -1;
    repeat (6) @(negedge clk);

    // key mismatch
    corrupt = 1'b1;
    run_base = ms_cnt;
    eg0 = eg_cnt;
    do_start(32'd23, 32'd5, 32'd6, 32'd15);
    wait_done(200);
    check_val("mis_err", err_code, 2);
    check_val("mis_n_enc_go", eg_cnt - eg0, 0);
    check_val("mis_n_me_start", ms_cnt - run_base, 4);
    corrupt = 1'b0;

    // encryption check failure, with a start attempted while busy
    enc_true = 1'b0;
    run_base = ms_cnt;
    eg0 = eg_cnt;
    do_start(32'd23, 32'd5, 32'd6, 32'd15);
    @(negedge clk);
    p = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (enc_go !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("enc_go_seen", enc_go, 1);
    @(posedge clk);
    @(negedge clk);
    check_val("enc_wait_not_done", done, 0);
    @(posedge clk);
    @(negedge clk);
    check_val("enc_err", err_code, 3);
    check_val("enc_done", done, 1);
    check_val("enc_n_me_start", ms_cnt - run_base, 4);
    check_val("enc_n_enc_go", eg_cnt - eg0, 1);
    enc_true = 1'b1;

    // reset during WAIT of job 2, followed by a late me_done
    run_base = ms_cnt;
    do_start(32'd23, 32'd5, 32'd6, 32'd15);
    n = 0;
    while (ms_cnt - run_base < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("rstw_third_issue", ms_cnt - run_base, 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rstw_busy", busy, 0);
    check_val("rstw_pub_a", pub_a, 0);
    check_val("rstw_pub_b", pub_b, 0);
    check_val("rstw_me_base", me_base, 0);
    check_val("rstw_err", err_code, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check_val("late_done_busy", busy, 0);
    check_val("late_done_done", done, 0);
    check_val("late_done_pub_a", pub_a, 0);
    check_val("late_done_key", key, 0);
    nominal_run("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dh_exchange_ctrl.md
Name: dh_exchange_ctrl

Overview:
- Sequences a full two-party Diffie-Hellman exchange on one shared modular-exponentiation unit (modexp), then triggers the encryption/verification stage.
- Issues four modexp jobs in fixed order: pub_a, pub_b, shared key A, shared key B.
- Cross-checks the two shared keys, pulses the encryption stage and reports pass or fail.
- Sits between the top-level test/host interface and the modexp and encryption datapaths.

Parameters:
- W, 32, width of p, g, secrets and results.
- TIMEOUT, 1024, maximum cycles to wait for me_done on one job; must be >= 2.
- ENC_LAT, 1, cycles from the enc_go pulse to sampling enc_true; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run an exchange; ignored unless idle
- p  in  W  modulus, sampled at accepted start
- g  in  W  generator, sampled at accepted start
- xa  in  W  party A secret, sampled at accepted start
- xb  in  W  party B secret, sampled at accepted start
- me_start  out  1  one-cycle pulse launching a modexp job
- me_base  out  W  job base, held stable until me_done
- me_exp  out  W  job exponent, held stable until me_done
- me_mod  out  W  job modulus, equal to the latched p
- me_done  in  1  one-cycle pulse: me_result valid
- me_result  in  W  base^exp mod p
- enc_go  out  1  one-cycle pulse to the encryption stage (its done_i_enc2)
- enc_true  in  1  encryption-stage check result
- pub_a  out  W  party A public value
- pub_b  out  W  party B public value
- key  out  W  agreed shared key, valid when done=1 and err_code=0
- busy  out  1  exchange in progress
- done  out  1  high in DONE and ERR until the next accepted start
- err_code  out  3  0 ok, 1 timeout, 2 key mismatch, 3 enc_true low, 4 bad modulus

Behaviour:
- Reset (async, rst=0): state IDLE, job=0, all outputs 0, and all latched operands, results and the timeout counter cleared. Reset mid-job abandons the job; any late me_done is ignored in IDLE.
- IDLE: start=1 latches p, g, xa and xb, clears done and err_code, and sets busy.
  - If p<2: go to ERR with code 4; no modexp job is issued.
  - Otherwise go to ISSUE with job=0.
- ISSUE (1 cycle): me_start=1 with operands chosen by job:
  - job 0: base g, exp xa
  - job 1: base g, exp xb
  - job 2: base pub_b, exp xa
  - job 3: base pub_a, exp xb
  - The timeout counter is cleared; next state is WAIT.
- WAIT: operands are held and the counter increments each cycle.
  - On me_done: store me_result to pub_a, pub_b, key_a or key_b according to job.
  - If job<3: job+1, back to ISSUE. If job=3: go to CHECK.
  - If the counter reaches TIMEOUT-1 without me_done: go to ERR with code 1.
  - me_done and timeout in the same cycle: me_done wins.
- CHECK (1 cycle):
  - key_a != key_b: go to ERR with code 2.
  - Otherwise key <= key_a and go to ENC.
- ENC (1 cycle): enc_go=1, counter cleared; next state ENC_WAIT.
- ENC_WAIT: count ENC_LAT cycles, then sample enc_true.
  - enc_true=1: go to DONE.
  - enc_true=0: go to ERR with code 3.
- DONE / ERR: busy=0, done=1; results and err_code are held. start=1 begins a new exchange as from IDLE, in the same cycle.
- start while busy is ignored, with no queuing.
- me_done outside WAIT is ignored.
- No arithmetic in this block; all values are passed through at W bits.
- Nominal latency: 1 (accept) + 4×(1 + modexp latency) + 1 (CHECK) + 1 (ENC) + ENC_LAT cycles.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ISSUE, WAIT, CHECK, ENC, ENC_WAIT, DONE, ERR)
  - job index constants (JOB_PUB_A=0, JOB_PUB_B=1, JOB_KEY_A=2, JOB_KEY_B=3)
  - error code constants (ERR_NONE=0, ERR_TMO=1, ERR_MISMATCH=2, ERR_ENC=3, ERR_MOD=4)
- One sub-module is natural: dh_job_mux, the combinational operand select by job index, reused by future multi-party controllers.
- FSM, counter and result registers stay in the top.

Test Plan:
- Nominal exchange: p=23, g=5, xa=6, xb=15; modexp model with 3-cycle latency; encryption model returns enc_true=1.
  -> pub_a=8, pub_b=19, key=2, err_code=0, done=1.
  -> Exactly 4 me_start pulses with bases 5, 5, 19, 8 and exponents 6, 15, 6, 15; exactly one enc_go.
- Bad modulus: p=1, start.
  -> ERR next cycle, err_code=4, no me_start.
- Timeout: TIMEOUT=16; model never asserts me_done on job 1.
  -> err_code=1 exactly 16 cycles after the second me_start; pub_a=8 retained.
- Mismatch: model corrupts job 3 result to 7.
  -> err_code=2, no enc_go.
- Encryption fail: enc_true=0.
  -> err_code=3 after enc_go + ENC_LAT; start during busy is ignored (me_start count unchanged).
- Reset mid-WAIT of job 2, then a late me_done.
  -> All outputs 0, state stays IDLE.
  -> A fresh start then completes the nominal case.
